seq_mult_ctrl: RTL

Sequencing controller for the shift-add sequential multiplier datapath. It accepts a start request and drives load, add and shift enables to the accumulator/adder and shift stages for exactly WIDTH_M add/shift iterations. It reports busy and a one-cycle done pulse to the requester, and supports a synchronous abort. It sits between the top-level multiplier wrapper and the datapath modules and contains no data registers of its own.

---
 rtl/seq_mult_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// seq_mult_ctrl
//
// Sequencing controller for a shift-add sequential multiplier datapath.
// Accepts a start request in IDLE, then drives one load cycle followed by
// WIDTH_M add/shift iteration pairs, and finishes with a one-cycle done
// pulse. Holds no data registers; only the FSM state and the step counter.
//
// Ports:
//   clk         in   clock, rising-edge active
//   reset       in   asynchronous, active-high reset
//   start       in   request a new multiplication (sampled only in IDLE)
//   abort       in   synchronous abort of a running operation
//   mult_lsb    in   bit 0 of the datapath multiplier register
//   load_en     out  load operands, clear accumulator and carry
//   add_en      out  add multiplicand into accumulator this cycle
//   shift_en    out  shift {carry, accumulator, multiplier} right by one
//   busy        out  multiplication in progress
//   done        out  one-cycle pulse, result valid in datapath
//   step_count  out  number of completed shift steps
// ---------------------------------------------------------------------------
module seq_mult_ctrl #(
    parameter int unsigned WIDTH_M = 16,
    localparam int unsigned CW     = $clog2(WIDTH_M) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          mult_lsb,
    output logic          load_en,
    output logic          add_en,
    output logic          shift_en,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] step_count
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StAdd   = 3'd2;
    localparam logic [2:0] StShift = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [CW-1:0] StepLast = CW'(WIDTH_M);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] step_q, step_d;
    logic [CW-1:0] step_inc;

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        step_inc = step_q + CW'(1);
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // Abort wins and leaves the counter untouched.
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    state_d = StAdd;
                    step_d  = '0;
                end
            end
            StAdd: begin
                state_d = abort ? StIdle : StShift;
            end
            StShift: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    step_d  = step_inc;
                    state_d = (step_inc == StepLast) ? StDone : StAdd;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Moore outputs, except add_en which follows mult_lsb within ADD.
    always_comb begin
        load_en  = (state_q == StLoad);
        add_en   = (state_q == StAdd) && mult_lsb;
        shift_en = (state_q == StShift);
        busy     = (state_q == StLoad) || (state_q == StAdd) || (state_q == StShift);
        done     = (state_q == StDone);
    end

    assign step_count = step_q;

endmodule
